// File: rtl/ascon_round_scheduler_if.sv
// Handshake and strobe bundle between the ASCON round scheduler,
// its register slave and the round datapath.
interface ascon_round_scheduler_if #(
  parameter int BLK_W = 16
);
  logic             start;
  logic [BLK_W-1:0] ad_blocks;
  logic [BLK_W-1:0] msg_blocks;
  logic             blk_valid;
  logic             blk_ready;
  logic             dp_load;
  logic             dp_round;
  logic [7:0]       dp_rc;
  logic             dp_key_xor_init;
  logic             dp_domsep;
  logic             dp_absorb;
  logic             dp_is_msg;
  logic             dp_last;
  logic             dp_key_xor_fin;
  logic             tag_valid;
  logic             tag_ready;
  logic             busy;
  logic             irq_en;
  logic             irq_ack;
  logic             irq;

  modport master (
    input  start, ad_blocks, msg_blocks,
    input  blk_valid, tag_ready,
    input  irq_en, irq_ack,
    output blk_ready,
    output dp_load, dp_round, dp_rc,
    output dp_key_xor_init, dp_domsep,
    output dp_absorb, dp_is_msg, dp_last,
    output dp_key_xor_fin,
    output tag_valid, busy, irq
  );

  modport slave (
    output start, ad_blocks, msg_blocks,
    output blk_valid, tag_ready,
    output irq_en, irq_ack,
    input  blk_ready,
    input  dp_load, dp_round, dp_rc,
    input  dp_key_xor_init, dp_domsep,
    input  dp_absorb, dp_is_msg, dp_last,
    input  dp_key_xor_fin,
    input  tag_valid, busy, irq
  );
endinterface

// File: rtl/ascon_round_scheduler.sv
// Control FSM sequencing the ASCON-128 AEAD round datapath:
// init p^a, AD/message absorb with p^b, finalization p^a, tag release.
module ascon_round_scheduler #(
  parameter int A_ROUNDS = 12,
  parameter int B_ROUNDS = 6,
  parameter int BLK_W    = 16
) (
  input logic                   ACLK,
  input logic                   ARESET,
  ascon_round_scheduler_if.master bus
);

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    PERM_A,
    KEYX,
    AD_WAIT,
    PERM_B,
    DOMSEP,
    MSG_WAIT,
    FINX,
    PERM_F,
    TAG
  } state_t;

  localparam logic [3:0] A_LAST = 4'(A_ROUNDS - 1);
  localparam logic [3:0] B_LAST = 4'(B_ROUNDS - 1);
  localparam logic [3:0] A_BASE = 4'(12 - A_ROUNDS);
  localparam logic [3:0] B_BASE = 4'(12 - B_ROUNDS);
  localparam logic [BLK_W-1:0] ONE = BLK_W'(1);

  state_t           state;
  logic [BLK_W-1:0] ad_cnt;
  logic [BLK_W-1:0] msg_cnt;
  logic [3:0]       rnd;
  logic             msg_ph;
  logic             irq_pend;

  logic       in_wait;
  logic       blk_hs;
  logic       tag_hs;
  logic       rnd_on;
  logic [3:0] idx;

  assign in_wait = (state == AD_WAIT) ||
                   (state == MSG_WAIT);
  assign blk_hs  = in_wait & bus.blk_valid;
  assign tag_hs  = (state == TAG) & bus.tag_ready;
  assign rnd_on  = (state == PERM_A) ||
                   (state == PERM_B) ||
                   (state == PERM_F);
  assign idx     = ((state == PERM_B) ? B_BASE
                                      : A_BASE) + rnd;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= IDLE;
      ad_cnt   <= '0;
      msg_cnt  <= '0;
      rnd      <= '0;
      msg_ph   <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      // completion beats a coincident acknowledge
      if (tag_hs)
        irq_pend <= 1'b1;
      else if (bus.irq_ack)
        irq_pend <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.start) begin
            ad_cnt  <= bus.ad_blocks;
            msg_cnt <= (bus.msg_blocks == '0) ?
                       ONE : bus.msg_blocks;
            state   <= LOAD;
          end
        end
        LOAD: begin
          rnd   <= '0;
          state <= PERM_A;
        end
        PERM_A: begin
          if (rnd == A_LAST) begin
            rnd   <= '0;
            state <= KEYX;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        KEYX: begin
          state <= (ad_cnt != '0) ? AD_WAIT
                                  : DOMSEP;
        end
        AD_WAIT: begin
          if (blk_hs) begin
            ad_cnt <= ad_cnt - ONE;
            msg_ph <= 1'b0;
            rnd    <= '0;
            state  <= PERM_B;
          end
        end
        PERM_B: begin
          if (rnd == B_LAST) begin
            rnd <= '0;
            if (msg_ph)
              state <= MSG_WAIT;
            else if (ad_cnt != '0)
              state <= AD_WAIT;
            else
              state <= DOMSEP;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        DOMSEP: begin
          state <= MSG_WAIT;
        end
        MSG_WAIT: begin
          if (blk_hs) begin
            msg_cnt <= msg_cnt - ONE;
            rnd     <= '0;
            if (msg_cnt == ONE) begin
              state <= FINX;
            end else begin
              msg_ph <= 1'b1;
              state  <= PERM_B;
            end
          end
        end
        FINX: begin
          rnd   <= '0;
          state <= PERM_F;
        end
        PERM_F: begin
          if (rnd == A_LAST) begin
            rnd   <= '0;
            state <= TAG;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        TAG: begin
          if (bus.tag_ready) begin
            msg_ph <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.blk_ready       = in_wait;
  assign bus.dp_load         = (state == LOAD);
  assign bus.dp_round        = rnd_on;
  assign bus.dp_rc           = rnd_on ?
                               {4'hF - idx, idx} : 8'h00;
  assign bus.dp_key_xor_init = (state == KEYX);
  assign bus.dp_domsep       = (state == DOMSEP);
  assign bus.dp_absorb       = blk_hs;
  assign bus.dp_is_msg       = blk_hs &
                               (state == MSG_WAIT);
  assign bus.dp_last         = blk_hs &
                               ((state == AD_WAIT) ?
                                (ad_cnt == ONE) :
                                (msg_cnt == ONE));
  assign bus.dp_key_xor_fin  = (state == FINX);
  assign bus.tag_valid       = (state == TAG);
  assign bus.busy            = (state != IDLE);
  assign bus.irq             = irq_pend & bus.irq_en;

endmodule

// File: tb/tb_ascon_round_scheduler.sv
// Scoreboard bench for ascon_round_scheduler: expected strobe stream
// is queued at start and compared against every progress cycle.
module tb_ascon_round_scheduler;

  typedef struct packed {
    logic       load;
    logic       round;
    logic [7:0] rc;
    logic       kxi;
    logic       dom;
    logic       absb;
    logic       msg;
    logic       last;
    logic       kxf;
    logic       tag;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ascon_round_scheduler_if #(.BLK_W(16)) bus ();

  ascon_round_scheduler #(
    .A_ROUNDS(12),
    .B_ROUNDS(6),
    .BLK_W(16)
  ) dut (
    .ACLK(clk),
    .ARESET(rst),
    .bus(bus)
  );

  logic [7:0] rc_tab [12] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  ev_t q[$];
  int  vectors = 0;
  int  errors  = 0;
  int  cyc     = 0;
  int  t0      = 0;
  int  load_cyc = 0;
  int  tag_cyc  = 0;
  int  tag_cnt  = 0;
  int  abs_cnt  = 0;
  bit  mon_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  function automatic ev_t obs_ev();
    ev_t e;
    e.load = bus.dp_load;
    e.round = bus.dp_round;
    e.rc = bus.dp_rc;
    e.kxi = bus.dp_key_xor_init;
    e.dom = bus.dp_domsep;
    e.absb = bus.dp_absorb;
    e.msg = bus.dp_is_msg;
    e.last = bus.dp_last;
    e.kxf = bus.dp_key_xor_fin;
    e.tag = bus.tag_valid & bus.tag_ready;
    return e;
  endfunction

  always @(negedge clk) begin
    ev_t e;
    ev_t x;
    e = obs_ev();
    if (!rst) begin
      if (e.load) load_cyc = cyc;
      if (e.absb) abs_cnt++;
      if (e.tag) begin
        tag_cnt++;
        tag_cyc = cyc;
      end
    end
    if (mon_en && !rst &&
        (e.load | e.round | e.kxi | e.dom |
         e.absb | e.kxf | e.tag)) begin
      vectors++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got %h expected none",
                 e);
      end else begin
        x = q.pop_front();
        if (e !== x) begin
          errors++;
          $display("FAIL sb_event @%0d: got %h expected %h",
                   cyc, e, x);
        end
      end
    end
  end

  task automatic push_op(input int ad, input int msg);
    int m = (msg == 0) ? 1 : msg;
    ev_t e;
    e = '0; e.load = 1'b1; q.push_back(e);
    for (int r = 0; r < 12; r++) begin
      e = '0; e.round = 1'b1; e.rc = rc_tab[r];
      q.push_back(e);
    end
    e = '0; e.kxi = 1'b1; q.push_back(e);
    for (int a = 1; a <= ad; a++) begin
      e = '0; e.absb = 1'b1; e.last = (a == ad);
      q.push_back(e);
      for (int r = 0; r < 6; r++) begin
        e = '0; e.round = 1'b1; e.rc = rc_tab[6 + r];
        q.push_back(e);
      end
    end
    e = '0; e.dom = 1'b1; q.push_back(e);
    for (int k = 1; k <= m; k++) begin
      e = '0; e.absb = 1'b1; e.msg = 1'b1;
      e.last = (k == m);
      q.push_back(e);
      if (k < m)
        for (int r = 0; r < 6; r++) begin
          e = '0; e.round = 1'b1; e.rc = rc_tab[6 + r];
          q.push_back(e);
        end
    end
    e = '0; e.kxf = 1'b1; q.push_back(e);
    for (int r = 0; r < 12; r++) begin
      e = '0; e.round = 1'b1; e.rc = rc_tab[r];
      q.push_back(e);
    end
    e = '0; e.tag = 1'b1; q.push_back(e);
  endtask

  task automatic do_start(input int ad, input int msg,
                          input int mad, input int mmsg,
                          input bit push);
    @(posedge clk); #1;
    bus.ad_blocks  = 16'(ad);
    bus.msg_blocks = 16'(msg);
    bus.start = 1'b1;
    t0 = cyc;
    if (push) push_op(mad, mmsg);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_tag(input int target,
                          output bit ok);
    int n = 0;
    while (tag_cnt < target && n < 400) begin
      @(posedge clk); #2;
      n++;
    end
    ok = (tag_cnt >= target);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.blk_ready, obs_ev(), bus.tag_valid,
         bus.busy, bus.irq} !== '0) begin
      errors++;
      $display("FAIL reset_outs: got %h expected 0",
               {bus.blk_ready, obs_ev(), bus.tag_valid,
                bus.busy, bus.irq});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    bit ok;
    do_start(0, 1, 0, 1, 1);
    wait_tag(tag_cnt + 1, ok);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout: tag=0 expected 1");
    end
    vectors++;
    if (load_cyc - t0 !== 1) begin
      errors++;
      $display("FAIL basic_load_lat: got %0d expected 1",
               load_cyc - t0);
    end
    vectors++;
    if (tag_cyc - t0 !== 30) begin
      errors++;
      $display("FAIL basic_tag_lat: got %0d expected 30",
               tag_cyc - t0);
    end
    vectors++;
    if (bus.busy !== 1'b0 || bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: busy=%b irq=%b expected 0 1",
               bus.busy, bus.irq);
    end
  endtask

  task automatic test_ad_msg;
    bit ok;
    int a0 = abs_cnt;
    do_start(2, 3, 2, 3, 1);
    wait_tag(tag_cnt + 1, ok);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL admsg_timeout: tag=0 expected 1");
    end
    vectors++;
    if (abs_cnt - a0 !== 5) begin
      errors++;
      $display("FAIL admsg_absorbs: got %0d expected 5",
               abs_cnt - a0);
    end
    vectors++;
    if (tag_cyc - t0 !== 58) begin
      errors++;
      $display("FAIL admsg_lat: got %0d expected 58",
               tag_cyc - t0);
    end
  endtask

  task automatic test_stall;
    bit ok;
    int n = 0;
    bus.blk_valid = 1'b0;
    bus.tag_ready = 1'b0;
    do_start(0, 2, 0, 2, 1);
    do begin @(negedge clk); n++; end
    while (!bus.blk_ready && n < 200);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (bus.blk_ready !== 1'b1 || obs_ev() !== '0 ||
          bus.tag_valid !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_msg[%0d]: rdy=%b ev=%h expected 1 0",
                 i, bus.blk_ready, obs_ev());
      end
    end
    @(posedge clk); #1;
    bus.blk_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus.tag_valid && n < 200);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (bus.tag_valid !== 1'b1 || obs_ev() !== '0 ||
          bus.blk_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_tag[%0d]: tv=%b ev=%h expected 1 0",
                 i, bus.tag_valid, obs_ev());
      end
    end
    @(posedge clk); #1;
    bus.tag_ready = 1'b1;
    wait_tag(tag_cnt + 1, ok);
    vectors++;
    if (!ok || tag_cyc - t0 !== 37 + 15) begin
      errors++;
      $display("FAIL stall_lat: got %0d expected 52",
               tag_cyc - t0);
    end
  endtask

  task automatic test_msg_zero;
    bit ok;
    bit extra = 1'b0;
    int tc = tag_cnt;
    do_start(0, 0, 0, 1, 1);
    @(posedge clk); #1;
    bus.ad_blocks  = 16'd5;
    bus.msg_blocks = 16'd5;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_tag(tc + 1, ok);
    vectors++;
    if (!ok || tag_cyc - t0 !== 30) begin
      errors++;
      $display("FAIL msg0_lat: got %0d expected 30",
               tag_cyc - t0);
    end
    repeat (20) begin
      @(negedge clk);
      if (bus.busy) extra = 1'b1;
    end
    vectors++;
    if (extra || tag_cnt - tc !== 1) begin
      errors++;
      $display("FAIL msg0_restart: tags=%0d busy=%b expected 1 0",
               tag_cnt - tc, extra);
    end
  endtask

  task automatic test_abort;
    bit ok;
    bit seen = 1'b0;
    int n = 0;
    int tc = tag_cnt;
    mon_en = 1'b0;
    do_start(1, 1, 1, 1, 0);
    do begin @(negedge clk); n++; end
    while (!bus.dp_absorb && n < 200);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({bus.blk_ready, obs_ev(), bus.tag_valid,
         bus.busy, bus.irq} !== '0) begin
      errors++;
      $display("FAIL abort_outs: got %h expected 0",
               {bus.blk_ready, obs_ev(), bus.tag_valid,
                bus.busy, bus.irq});
    end
    repeat (40) begin
      @(negedge clk);
      if (bus.tag_valid || bus.busy) seen = 1'b1;
    end
    vectors++;
    if (seen || tag_cnt !== tc) begin
      errors++;
      $display("FAIL abort_tag: seen=%b tags=%0d expected 0 %0d",
               seen, tag_cnt, tc);
    end
    mon_en = 1'b1;
    do_start(1, 1, 1, 1, 1);
    wait_tag(tc + 1, ok);
    vectors++;
    if (!ok || tag_cyc - t0 !== 37) begin
      errors++;
      $display("FAIL abort_rerun: got %0d expected 37",
               tag_cyc - t0);
    end
  endtask

  task automatic test_irq;
    bit ok;
    int n = 0;
    bus.irq_en = 1'b0;
    do_start(0, 1, 0, 1, 1);
    wait_tag(tag_cnt + 1, ok);
    vectors++;
    if (!ok || bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_masked: got %b expected 0", bus.irq);
    end
    bus.irq_en = 1'b1;
    #1;
    vectors++;
    if (bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_enable: got %b expected 1", bus.irq);
    end
    @(posedge clk); #1;
    bus.irq_ack = 1'b1;
    @(posedge clk); #1;
    bus.irq_ack = 1'b0;
    vectors++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_ack: got %b expected 0", bus.irq);
    end
    bus.tag_ready = 1'b0;
    do_start(0, 1, 0, 1, 1);
    do begin @(negedge clk); n++; end
    while (!bus.tag_valid && n < 200);
    vectors++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_pre_tag: got %b expected 0", bus.irq);
    end
    @(posedge clk); #1;
    bus.tag_ready = 1'b1;
    bus.irq_ack = 1'b1;
    @(posedge clk); #1;
    bus.irq_ack = 1'b0;
    vectors++;
    if (bus.irq !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL irq_set_wins: irq=%b busy=%b expected 1 0",
               bus.irq, bus.busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.ad_blocks = '0;
    bus.msg_blocks = '0;
    bus.blk_valid = 1'b1;
    bus.tag_ready = 1'b1;
    bus.irq_en = 1'b1;
    bus.irq_ack = 1'b0;
    test_reset;
    mon_en = 1'b1;
    test_basic;
    test_ad_msg;
    test_stall;
    test_msg_zero;
    test_abort;
    test_irq;
    repeat (2) @(negedge clk);
    vectors++;
    if (q.size() !== 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
